// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: op enumeration, opcode fields, immediate widths.
// Used by the encoder datapath and by any decoder built against the same ISA subset.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR, OP_ADD, OP_SUB,
    OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_MOVK, OP_ILLEGAL
  } op_e;

  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
  localparam logic [8:0]  OPC_MOVK = 9'b111100101;

  localparam int unsigned IMM_W_B   = 26;
  localparam int unsigned IMM_W_CB  = 19;
  localparam int unsigned IMM_W_D   = 9;
  localparam int unsigned IMM_W_I   = 12;
  localparam int unsigned IMM_W_MOV = 16;

  localparam logic [31:0] ADDR_STEP = 32'd4;

  // A value fits a w-bit signed field when bits [31:w-1] are all equal.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (w - 1);
    return ((v & mask) == 32'h0) || ((v & mask) == mask);
  endfunction

  function automatic logic fits_unsigned(input logic [31:0] v, input int unsigned w);
    return (v >> w) == 32'h0;
  endfunction

endpackage

// File: rtl/legv8_encode_field.sv
// Combinational field packer: (op, regs, imm, hw) -> 32-bit word plus reject flag.
// Zero latency; no flow control of its own.
module legv8_encode_field
  import legv8_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [31:0] imm,
  input  logic [1:0]  hw,
  output logic [31:0] word,
  output logic        reject
);

  op_e op_q;
  assign op_q = op_e'(op);

  always_comb begin
    word   = '0;
    reject = 1'b0;
    case (op_q)
      OP_B, OP_BL: begin
        word   = {(op_q == OP_B) ? OPC_B : OPC_BL, imm[25:0]};
        reject = !fits_signed(imm, IMM_W_B);
      end
      OP_CBZ, OP_CBNZ: begin
        word   = {(op_q == OP_CBZ) ? OPC_CBZ : OPC_CBNZ, imm[18:0], rd};
        reject = !fits_signed(imm, IMM_W_CB);
      end
      // STUR's data register travels on rd, same slot as LDUR's destination.
      OP_LDUR, OP_STUR: begin
        word   = {(op_q == OP_LDUR) ? OPC_LDUR : OPC_STUR, imm[8:0], 2'b00, rn, rd};
        reject = !fits_signed(imm, IMM_W_D);
      end
      OP_ADD: word = {OPC_ADD, rm, 6'b000000, rn, rd};
      OP_SUB: word = {OPC_SUB, rm, 6'b000000, rn, rd};
      OP_AND: word = {OPC_AND, rm, 6'b000000, rn, rd};
      OP_ORR: word = {OPC_ORR, rm, 6'b000000, rn, rd};
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
        word   = {(op_q == OP_ADDI) ? OPC_ADDI :
                  (op_q == OP_SUBI) ? OPC_SUBI :
                  (op_q == OP_ANDI) ? OPC_ANDI : OPC_ORRI, imm[11:0], rn, rd};
        reject = !fits_signed(imm, IMM_W_I);
      end
      OP_MOVK: begin
        word   = {OPC_MOVK, hw, imm[15:0], rd};
        reject = !fits_unsigned(imm, IMM_W_MOV);
      end
      default: reject = 1'b1;
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Encodes LEGv8 requests into words with byte addresses; one cycle request->out_valid.
// Single-entry output register; in_ready drops while a word is stalled or start is high.
module legv8_instr_encoder
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_hw,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] word_count
);

  logic [31:0] word;
  logic        reject;
  logic [31:0] cnt;
  logic        accept;
  logic        emit;
  logic        drain;

  legv8_encode_field u_enc (
    .op     (in_op),
    .rd     (in_rd),
    .rn     (in_rn),
    .rm     (in_rm),
    .imm    (in_imm),
    .hw     (in_hw),
    .word   (word),
    .reject (reject)
  );

  assign in_ready = !start && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = accept && !reject;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_addr   <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= cnt;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      // start never coincides with accept, so a pending word keeps its address.
      if (start) begin
        cnt <= {base_addr[31:2], 2'b00};
      end else if (emit) begin
        cnt <= cnt + ADDR_STEP;
      end

      if (accept && reject) begin
        err <= 1'b1;
      end

      if (start) begin
        word_count <= '0;
      end else if (drain && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Bench for legv8_instr_encoder: directed literal scenarios, then randomized traffic
// compared every cycle against a queue-based reference model.
module tb_legv8_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, out_valid, out_ready, err;
  logic [31:0] base_addr, in_imm, out_instr, out_addr;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [1:0]  in_hw;
  logic [15:0] word_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  legv8_instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_hw(in_hw),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .word_count(word_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoding built from integer opcode values and shifted fields.
  function automatic void ref_encode(input int op, input int rd, input int rn, input int rm,
                                     input int imm, input int hw,
                                     output logic [31:0] w, output bit rej);
    logic [31:0] ui;
    ui  = imm;
    w   = 32'h0;
    rej = 1'b0;
    case (op)
      0, 1: begin
        rej = !(imm >= -(1 <<< 25) && imm < (1 <<< 25));
        w = (((op == 0) ? 32'h5 : 32'h25) << 26) | (ui & 32'h03FF_FFFF);
      end
      2, 3: begin
        rej = !(imm >= -(1 <<< 18) && imm < (1 <<< 18));
        w = (((op == 2) ? 32'hB4 : 32'hB5) << 24) | ((ui & 32'h7FFFF) << 5) | rd;
      end
      4, 5: begin
        rej = !(imm >= -256 && imm < 256);
        w = (((op == 4) ? 32'h7C2 : 32'h7C0) << 21) | ((ui & 32'h1FF) << 12) | (rn << 5) | rd;
      end
      6, 7, 8, 9: begin
        logic [31:0] opc;
        opc = (op == 6) ? 32'h458 : (op == 7) ? 32'h658 : (op == 8) ? 32'h450 : 32'h550;
        w = (opc << 21) | (rm << 16) | (rn << 5) | rd;
      end
      10, 11, 12, 13: begin
        logic [31:0] opc;
        opc = (op == 10) ? 32'h244 : (op == 11) ? 32'h344 : (op == 12) ? 32'h248 : 32'h2C8;
        rej = !(imm >= -2048 && imm < 2048);
        w = (opc << 22) | ((ui & 32'hFFF) << 10) | (rn << 5) | rd;
      end
      14: begin
        rej = !(imm >= 0 && imm <= 65535);
        w = (32'h1E5 << 23) | (hw << 21) | ((ui & 32'hFFFF) << 5) | rd;
      end
      default: rej = 1'b1;
    endcase
  endfunction

  // Reference model: queue of words awaiting downstream acceptance.
  typedef struct { logic [31:0] instr; logic [31:0] addr; } word_t;
  word_t       q[$];
  logic [31:0] m_cnt;
  bit          m_err;
  int          m_wc;
  bit          m_init = 1'b0;

  always @(posedge clk) begin
    bit          hs, rdy, rej;
    logic [31:0] w;
    m_init = 1'b1;
    if (reset) begin
      q.delete();
      m_cnt = 0; m_err = 0; m_wc = 0;
    end else begin
      hs  = (q.size() != 0) && out_ready;
      rdy = !start && ((q.size() == 0) || out_ready);
      if (hs) void'(q.pop_front());
      if (start) m_wc = 0;
      else if (hs && m_wc < 65535) m_wc++;
      if (start) m_cnt = base_addr & 32'hFFFF_FFFC;
      if (in_valid && rdy) begin
        ref_encode(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), int'(in_imm),
                   int'(in_hw), w, rej);
        if (rej) m_err = 1'b1;
        else begin
          q.push_back('{instr: w, addr: m_cnt});
          m_cnt = m_cnt + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("mdl_out_instr", out_instr, q[0].instr);
        chk("mdl_out_addr", out_addr, q[0].addr);
      end
      chk("mdl_in_ready", {31'b0, in_ready},
          {31'b0, !start && ((q.size() == 0) || out_ready)});
      chk("mdl_err", {31'b0, err}, {31'b0, m_err});
      chk("mdl_word_count", {16'b0, word_count}, m_wc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int op, input int rd, input int rn, input int rm, input int imm);
    in_valid = 1'b1;
    in_op = op[3:0]; in_rd = rd[4:0]; in_rn = rn[4:0]; in_rm = rm[4:0];
    in_imm = imm; in_hw = 2'd0;
  endtask

  function automatic int pick_imm(input int op);
    int w;
    longint lo, hi, v;
    case (op)
      0, 1:           w = 26;
      2, 3:           w = 19;
      4, 5:           w = 9;
      10, 11, 12, 13: w = 12;
      default:        w = 16;
    endcase
    if (op == 14) begin lo = 0; hi = 65535; end
    else begin lo = -(longint'(1) << (w - 1)); hi = (longint'(1) << (w - 1)) - 1; end
    case ($urandom_range(0, 5))
      0:       v = longint'($signed($urandom()));
      1:       v = hi;
      2:       v = lo;
      3:       v = hi + 1;
      4:       v = lo - 1;
      default: v = lo + longint'($urandom_range(0, 32'(hi - lo)));
    endcase
    return int'(v);
  endfunction

  initial begin
    logic [31:0] w;
    bit          rej;

    ref_encode(10, 1, 2, 0, 5, 0, w, rej);      chk("ref_addi", w, 32'h91001441);
    ref_encode(6, 0, 1, 2, 0, 0, w, rej);       chk("ref_add", w, 32'h8B020020);
    ref_encode(4, 3, 4, 0, 8, 0, w, rej);       chk("ref_ldur", w, 32'hF8408083);
    ref_encode(0, 0, 0, 0, -1, 0, w, rej);      chk("ref_b_neg1", w, 32'h17FFFFFF);
    ref_encode(14, 5, 0, 0, 32'h1234, 1, w, rej); chk("ref_movk", w, 32'hF2A24685);
    ref_encode(5, 1, 2, 0, -1, 0, w, rej);      chk("ref_stur", w, 32'hF81FF041);
    ref_encode(2, 0, 0, 0, 32'h40000, 0, w, rej); chk("ref_cbz_range", {31'b0, rej}, 32'd1);

    reset = 1; start = 0; base_addr = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0; in_hw = 0;
    tick(); tick();
    reset = 0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_word_count", {16'b0, word_count}, 32'd0);
    #1 chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    start = 1; base_addr = 32'h100;
    #1 chk("start_blocks_ready", {31'b0, in_ready}, 32'd0);
    tick(); start = 0;
    set_req(10, 1, 2, 0, 5); tick(); in_valid = 0;
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_instr", out_instr, 32'h91001441);
    chk("addi_addr", out_addr, 32'h100);

    start = 1; tick(); start = 0;
    set_req(6, 0, 1, 2, 0); tick();
    chk("b2b_add_instr", out_instr, 32'h8B020020);
    chk("b2b_add_addr", out_addr, 32'h100);
    set_req(4, 3, 4, 0, 8); tick();
    chk("b2b_ldur_instr", out_instr, 32'hF8408083);
    chk("b2b_ldur_addr", out_addr, 32'h104);

    set_req(0, 0, 0, 0, -1); tick();
    chk("b_instr", out_instr, 32'h17FFFFFF);
    chk("b_addr", out_addr, 32'h108);
    set_req(2, 0, 0, 0, 32'h40000); tick(); in_valid = 0;
    chk("cbz_rej_valid", {31'b0, out_valid}, 32'd0);
    chk("cbz_rej_err", {31'b0, err}, 32'd1);
    set_req(10, 1, 2, 0, 5); tick(); in_valid = 0;
    chk("after_rej_addr", out_addr, 32'h10C);
    tick();

    out_ready = 0;
    set_req(6, 0, 1, 2, 0); tick();
    set_req(10, 1, 2, 0, 5);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_instr", out_instr, 32'h8B020020);
      chk("stall_addr", out_addr, 32'h110);
      tick();
    end
    out_ready = 1; tick(); in_valid = 0;
    chk("release_instr", out_instr, 32'h91001441);
    chk("release_addr", out_addr, 32'h114);
    tick();
    chk("release_drained", {31'b0, out_valid}, 32'd0);

    start = 1; base_addr = 32'hFFFF_FFFE; tick(); start = 0;
    set_req(6, 0, 1, 2, 0); tick();
    chk("wrap_addr0", out_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", out_addr, 32'h0000_0000);
    in_valid = 0; tick();

    out_ready = 0;
    set_req(6, 0, 1, 2, 0); tick(); in_valid = 0;
    start = 1; base_addr = 32'h200; tick(); start = 0;
    chk("start_pend_valid", {31'b0, out_valid}, 32'd1);
    chk("start_pend_addr", out_addr, 32'h4);
    chk("start_wc_clear", {16'b0, word_count}, 32'd0);
    out_ready = 1;
    set_req(7, 3, 4, 5, 0); tick(); in_valid = 0;
    chk("reload_instr", out_instr, 32'hCB050083);
    chk("reload_addr", out_addr, 32'h200);
    chk("reload_wc", {16'b0, word_count}, 32'd1);

    out_ready = 0;
    reset = 1; tick(); reset = 0;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    chk("midrst_wc", {16'b0, word_count}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      int op;
      op        = $urandom_range(0, 15);
      reset     = ($urandom_range(0, 600) == 0);
      start     = ($urandom_range(0, 40) == 0);
      base_addr = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = op[3:0];
      in_rd     = 5'($urandom_range(0, 31));
      in_rn     = 5'($urandom_range(0, 31));
      in_rm     = 5'($urandom_range(0, 31));
      in_hw     = 2'($urandom_range(0, 3));
      in_imm    = pick_imm(op);
      tick();
    end
    reset = 0; start = 0; in_valid = 0; out_ready = 1;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/legv8_instr_encoder.md
LEGV8_INSTR_ENCODER -- requirements
Module: legv8_instr_encoder

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; loads the address counter from base_addr.
REQ-005 base_addr  input  32  byte address of the first emitted word; bits [1:0] ignored (forced 0).
REQ-006 in_valid / in_ready  input / output  1 / 1  request handshake; transfer when both are high on a rising edge.
REQ-007 in_op  input  4  0 B, 1 BL, 2 CBZ, 3 CBNZ, 4 LDUR, 5 STUR, 6 ADD, 7 SUB, 8 AND, 9 ORR, 10 ADDI, 11 SUBI, 12 ANDI, 13 ORRI, 14 MOVK, 15 illegal.
REQ-008 in_rd, in_rn, in_rm  input  5 each  Rd/Rt, Rn, Rm register indices.
REQ-009 in_imm  input  32 signed  immediate or branch offset in words.
REQ-010 in_hw  input  2  MOVK shift field.
REQ-011 out_valid / out_ready  output / input  1 / 1  emitted-word handshake.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_addr  output  32  byte address for out_instr.
REQ-014 err  output  1  sticky; set on any rejected request.
REQ-015 word_count  output  16  count of words accepted downstream since reset or start; saturates at 0xFFFF.

Function
REQ-016 Encodings:
- B/BL: {000101 or 100101, imm[25:0]}.
- CBZ/CBNZ: {10110100 or 10110101, imm[18:0], Rt}.
- LDUR/STUR: {11111000010 or 11111000000, imm[8:0], 00, Rn, Rt}; STUR places the data register (in_rd) in [4:0].
- ADD/SUB/AND/ORR: {10001011000, 11001011000, 10001010000 or 10101010000, Rm, 000000, Rn, Rd}.
- ADDI/SUBI/ANDI/ORRI: {1001000100, 1101000100, 1001001000 or 1011001000, imm[11:0], Rn, Rd}.
- MOVK: {111100101, hw, imm[15:0], Rd}.
REQ-017 Immediate ranges: B/BL signed 26-bit; CB signed 19-bit; LDUR/STUR signed 9-bit; I-type signed 12-bit; MOVK unsigned 0..65535. Out-of-range values and in_op=15 are rejected.
REQ-018 A rejected request is consumed: in_ready behaves normally, no word is emitted, the address does not advance, and err sets the next cycle.
REQ-019 Output stage is a single-entry register; latency is exactly one cycle from input handshake to out_valid.
REQ-020 in_ready = !start && (!out_valid || out_ready), which permits full throughput at one word per cycle.
REQ-021 out_valid, out_instr, and out_addr hold stable while out_valid && !out_ready.
REQ-022 Address counter: out_addr takes the counter value at accept; the counter advances by 4 on each accepted, non-rejected request and wraps from 0xFFFFFFFC to 0.
REQ-023 start in the same cycle as in_valid: start wins, and the request is not accepted that cycle.
REQ-024 start while out_valid is high: the pending word keeps its address and stays valid; the counter reloads; word_count clears.
REQ-025 word_count increments on each out_valid && out_ready.

Reset
REQ-026 On reset: out_valid=0, out_instr=0, out_addr=0, counter=0, err=0, word_count=0. in_ready follows REQ-020 (high unless start).
REQ-027 Reset mid-handshake discards any pending word; reset has priority over start.

Structure
REQ-028 A shared package legv8_pkg holds the op enumeration, opcode field constants, and immediate width constants; the decoder uses the same package.
REQ-029 One combinational sub-module, legv8_encode_field, maps (op, regs, imm, hw) to {word, reject}; the top module holds the handshake, counter, and flags.

Verification
REQ-030 start base_addr=0x100; send ADDI Rd=1 Rn=2 imm=5 -> out_instr=0x91001441, out_addr=0x100, one cycle later.
REQ-031 Back-to-back ADD X0,X1,X2 then LDUR Rt=3 Rn=4 imm=8 with out_ready=1 -> 0x8B020020 @0x100, then 0xF8408083 @0x104, no bubble.
REQ-032 B imm=-1 -> 0x17FFFFFF; CBZ imm=0x40000 -> no output, err=1, address unchanged.
REQ-033 Hold out_ready=0 for 3 cycles with a second request waiting -> in_ready=0, out_instr stable; release -> both words emitted in order.
REQ-034 base_addr=0xFFFFFFFC, two requests -> out_addr 0xFFFFFFFC then 0x00000000.
REQ-035 Assert reset while out_valid=1 -> next cycle out_valid=0, err=0, word_count=0.
